// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Helpers work on a fixed maximum width; callers pass their real width
// and truncate the result with a width cast.
package rr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    localparam int unsigned ARB_MAX_W     = 64;
    localparam int unsigned ARB_MAX_IDX_W = 6;

    // One-hot rotate left by one within 'width' bits; MSB wraps to LSB.
    function automatic logic [ARB_MAX_W-1:0] rotl1(input logic [ARB_MAX_W-1:0] oh,
                                                    input int unsigned          width);
        logic [ARB_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ARB_MAX_W; i++) begin
            if (i < width) begin
                r[(i + 1 == width) ? 0 : i + 1] = oh[i];
            end
        end
        return r;
    endfunction

    // One-hot to binary by OR-ing the indices of set bits (no priority).
    function automatic logic [ARB_MAX_IDX_W-1:0] oh2idx(input logic [ARB_MAX_W-1:0] oh,
                                                         input int unsigned          width);
        logic [ARB_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < ARB_MAX_W; i++) begin
            if (i < width && oh[i]) begin
                idx = idx | i[ARB_MAX_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/find_first1_base.sv
// Finds the first set bit of 'req' scanning upward from the one-hot 'base',
// wrapping past the MSB. Result is one-hot, or zero when 'req' is zero.
module find_first1_base #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] win
);

    logic [2*WIDTH-1:0] dbl_req;
    logic [2*WIDTH-1:0] dbl_win;

    // Doubled-vector subtract: borrow ripples from base up to the first request.
    always_comb begin
        dbl_req = {req, req};
        dbl_win = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
        win     = dbl_win[WIDTH-1:0] | dbl_win[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst lock: a grant stays on one requester until
// its beat flagged last is accepted; the rotation base advances only then.
// Optional feature macro: RR_ARB_PERF_EN (adds grant/stall counters).
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_last,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_last,
`ifdef RR_ARB_PERF_EN
    output logic [31:0]        perf_grant_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    input  logic               gnt_ready
);

    arb_state_e         state, state_nx;
    logic [NUM_REQ-1:0] base, base_nx;
    logic [NUM_REQ-1:0] lock_oh, lock_nx;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] sel_oh;
    logic               sel_valid;
    logic               out_en;
    logic               fire;

    find_first1_base #(.WIDTH(NUM_REQ)) u_pick (
        .req  (req_valid),
        .base (base),
        .win  (win)
    );

    // Grant selection, output gating and next-state decode.
    always_comb begin
        state_nx = state;
        base_nx  = base;
        lock_nx  = lock_oh;

        if (state == ARB_LOCK) begin
            sel_oh    = lock_oh;
            sel_valid = |(req_valid & lock_oh);
        end else begin
            sel_oh    = win;
            sel_valid = |req_valid;
        end

        // Outputs read zero while in reset or during a flush cycle.
        out_en    = reset_n & ~flush;
        gnt_oh    = out_en ? sel_oh : '0;
        gnt_valid = out_en & sel_valid;
        gnt_last  = out_en & |(req_last & sel_oh);
        gnt_idx   = IDX_W'(oh2idx(ARB_MAX_W'(gnt_oh), NUM_REQ));
        fire      = gnt_valid & gnt_ready;

        if (flush) begin
            state_nx = ARB_IDLE;
            lock_nx  = '0;
        end else if (fire) begin
            if (gnt_last) begin
                base_nx  = NUM_REQ'(rotl1(ARB_MAX_W'(gnt_oh), NUM_REQ));
                lock_nx  = '0;
                state_nx = ARB_IDLE;
            end else begin
                lock_nx  = gnt_oh;
                state_nx = ARB_LOCK;
            end
        end
    end

    // State, rotation base, burst lock and optional performance counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ARB_IDLE;
            base           <= NUM_REQ'(1);
            lock_oh        <= '0;
`ifdef RR_ARB_PERF_EN
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
`endif
        end else begin
            state          <= state_nx;
            base           <= base_nx;
            lock_oh        <= lock_nx;
`ifdef RR_ARB_PERF_EN
            if (fire && gnt_last) perf_grant_cnt <= perf_grant_cnt + 32'd1;
            if (gnt_valid && !gnt_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
        end
    end

    a_gnt_oh_onehot0:  assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt_oh));
    a_base_onehot:     assert property (@(posedge clock) disable iff (!reset_n) $onehot(base));
    a_lock_onehot0:    assert property (@(posedge clock) disable iff (!reset_n) $onehot0(lock_oh));
    a_lock_iff_state:  assert property (@(posedge clock) disable iff (!reset_n)
                                        ((state == ARB_LOCK) == (lock_oh != '0)));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter with NUM_REQ=4.
module tb_rr_burst_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [3:0] gnt_oh;
    logic [1:0] gnt_idx;
    logic       gnt_last;
`ifdef RR_ARB_PERF_EN
    logic [31:0] perf_grant_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: integer rotation base, lock flag and locked index.
    int   m_base;
    bit   m_locked;
    int   m_lock;
    int   m_sel;
    int   p_grant;
    int   p_stall;
    bit       e_valid;
    bit       e_last;
    bit [1:0] e_idx;
    bit [3:0] e_oh;

    always #5 clock = ~clock;

    rr_burst_arbiter #(.NUM_REQ(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_last  (req_last),
        .gnt_valid (gnt_valid),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_last  (gnt_last),
`ifdef RR_ARB_PERF_EN
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .gnt_ready (gnt_ready)
    );

    task automatic model_reset();
        m_base = 0; m_locked = 0; m_lock = 0; m_sel = 0;
        p_grant = 0; p_stall = 0;
    endtask

    task automatic model_outputs();
        bit found;
        found = 0;
        m_sel = 0;
        if (m_locked) begin
            m_sel   = m_lock;
            e_valid = req_valid[m_lock];
            e_last  = req_last[m_lock];
            found   = 1;
        end else begin
            e_valid = 0;
            e_last  = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req_valid[(m_base + k) % 4]) begin
                    found   = 1;
                    m_sel   = (m_base + k) % 4;
                    e_valid = 1;
                    e_last  = req_last[m_sel];
                end
            end
        end
        e_oh  = found ? (4'b0001 << m_sel) : 4'b0000;
        e_idx = found ? 2'(m_sel) : 2'd0;
        if (flush) begin
            e_valid = 0; e_last = 0; e_oh = 0; e_idx = 0;
        end
    endtask

    task automatic model_update();
        if (e_valid && e_last && gnt_ready) p_grant++;
        if (e_valid && !gnt_ready) p_stall++;
        if (flush) begin
            m_locked = 0;
        end else if (e_valid && gnt_ready) begin
            if (e_last) begin
                m_base   = (m_sel + 1) % 4;
                m_locked = 0;
            end else begin
                m_locked = 1;
                m_lock   = m_sel;
            end
        end
    endtask

    task automatic step(input bit f, input bit [3:0] v, input bit [3:0] l, input bit r);
        @(negedge clock);
        flush = f; req_valid = v; req_last = l; gnt_ready = r;
        #1;
        model_outputs();
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0; flush = 0; req_valid = 0; req_last = 0; gnt_ready = 0;
        @(negedge clock);
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 0; flush = 0; req_valid = 4'b1111; req_last = 4'b1111; gnt_ready = 1;
        #1;
        checks++;
        if ({gnt_valid, gnt_last, gnt_idx, gnt_oh} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", {gnt_valid, gnt_last, gnt_idx, gnt_oh});
        end
`ifdef RR_ARB_PERF_EN
        checks++;
        if (perf_grant_cnt !== 0 || perf_stall_cnt !== 0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_grant_cnt, perf_stall_cnt);
        end
`endif
        @(negedge clock);
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_rotation();
        bit [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b1111, 4'b1111, 1);
            checks++;
            if (gnt_idx !== seq[k] || gnt_oh !== (4'b0001 << seq[k]) || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation[%0d]: got idx %0d oh %b valid %b expected idx %0d",
                         k, gnt_idx, gnt_oh, gnt_valid, seq[k]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 4'b0001, 4'b1111, 1); tick();
        step(0, 4'b0010, 4'b1111, 1); tick();
        step(0, 4'b0011, 4'b1111, 1);
        checks++;
        if (gnt_oh !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant: got %b expected 0001", gnt_oh);
        end
        tick();
        step(0, 4'b0011, 4'b1111, 1);
        checks++;
        if (gnt_oh !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_base_next: got %b expected 0010", gnt_oh);
        end
        tick();
    endtask

    task automatic test_burst();
        bit [3:0] lasts [3] = '{4'b0010, 4'b0010, 4'b0011};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b0011, lasts[k], 1);
            checks++;
            if (gnt_oh !== 4'b0001 || gnt_last !== (k == 2)) begin
                errors++;
                $display("FAIL burst_beat[%0d]: got oh %b last %b expected oh 0001 last %0d",
                         k, gnt_oh, gnt_last, (k == 2));
            end
            tick();
        end
        step(0, 4'b0011, 4'b0011, 1);
        checks++;
        if (gnt_oh !== 4'b0010) begin
            errors++;
            $display("FAIL burst_after: got %b expected 0010", gnt_oh);
        end
        tick();
    endtask

    task automatic test_stall();
`ifdef RR_ARB_PERF_EN
        logic [31:0] stall0;
`endif
        do_reset();
        step(0, 4'b0100, 4'b0000, 1); tick();
`ifdef RR_ARB_PERF_EN
        stall0 = perf_stall_cnt;
`endif
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b1111, 4'b0000, 0);
            checks++;
            if (gnt_oh !== 4'b0100 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got oh %b valid %b expected 0100 1", k, gnt_oh, gnt_valid);
            end
            tick();
        end
        step(0, 4'b1111, 4'b1111, 1);
`ifdef RR_ARB_PERF_EN
        checks++;
        if (perf_stall_cnt - stall0 !== 32'd5) begin
            errors++;
            $display("FAIL stall_perf: got delta %0d expected 5", perf_stall_cnt - stall0);
        end
`endif
        checks++;
        if (gnt_oh !== 4'b0100 || gnt_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got oh %b last %b expected 0100 1", gnt_oh, gnt_last);
        end
        tick();
        step(0, 4'b1111, 4'b1111, 1);
        checks++;
        if (gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL stall_next_base: got idx %0d expected 3", gnt_idx);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        step(0, 4'b1000, 4'b0000, 1); tick();
        step(1, 4'b1111, 4'b1111, 1);
        checks++;
        if ({gnt_valid, gnt_last, gnt_idx, gnt_oh} !== 8'h00) begin
            errors++;
            $display("FAIL flush_outputs: got %b expected 00000000", {gnt_valid, gnt_last, gnt_idx, gnt_oh});
        end
        tick();
        step(0, 4'b1111, 4'b1111, 1);
        checks++;
        if (gnt_oh !== 4'b0001) begin
            errors++;
            $display("FAIL flush_idle_base: got %b expected 0001", gnt_oh);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 4'b0001, 4'b1111, 1); tick();
        step(0, 4'b0010, 4'b0000, 1); tick();
        step(0, 4'b1111, 4'b0000, 1);
        checks++;
        if (gnt_oh !== 4'b0010) begin
            errors++;
            $display("FAIL areset_locked: got %b expected 0010", gnt_oh);
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if ({gnt_valid, gnt_last, gnt_idx, gnt_oh} !== 8'h00) begin
            errors++;
            $display("FAIL areset_outputs: got %b expected 00000000", {gnt_valid, gnt_last, gnt_idx, gnt_oh});
        end
        @(negedge clock);
        reset_n = 1;
        model_reset();
        step(0, 4'b1111, 4'b1111, 1);
        checks++;
        if (gnt_oh !== 4'b0001) begin
            errors++;
            $display("FAIL areset_base: got %b expected 0001", gnt_oh);
        end
        tick();
    endtask

    task automatic test_random();
        bit [3:0] v, l;
        bit f, r;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            f = ($urandom_range(0, 15) == 0);
            v = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0);
            step(f, v, l, r);
            checks++;
            if ({gnt_valid, gnt_last, gnt_idx, gnt_oh} !== {e_valid, e_last, e_idx, e_oh}) begin
                errors++;
                $display("FAIL random[%0d]: got v%b l%b i%0d oh%b expected v%b l%b i%0d oh%b", k,
                         gnt_valid, gnt_last, gnt_idx, gnt_oh, e_valid, e_last, e_idx, e_oh);
            end
`ifdef RR_ARB_PERF_EN
            checks++;
            if (perf_grant_cnt !== 32'(p_grant) || perf_stall_cnt !== 32'(p_stall)) begin
                errors++;
                $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", k,
                         perf_grant_cnt, perf_stall_cnt, p_grant, p_stall);
            end
`endif
            tick();
        end
    endtask

    initial begin
        reset_n = 0; flush = 0; req_valid = 0; req_last = 0; gnt_ready = 0;
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_burst();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
